// File: rtl/axi_line_refill.sv
// Cache line refill engine: one AXI INCR burst per miss, line returned whole.
// Ports: miss_* in, refill_* out, bus_req/bus_grnt arbiter, AR/R AXI channels.
module axi_line_refill #(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] ID         = 4'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_valid,
  input  logic [31:0]              miss_addr,
  output logic                     miss_ready,
  output logic                     refill_valid,
  output logic [32*LINE_WORDS-1:0] refill_data,
  output logic                     refill_err,
  output logic                     bus_req,
  input  logic                     bus_grnt,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [3:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam int          CW    = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [31:0] OMASK = 32'(LINE_WORDS * 4 - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, ADDR, DATA, DONE
  } state_e;

  state_e state_q, state_d;

  logic [LINE_WORDS-1:0][31:0] line_q;
  logic [31:0]   addr_q;
  logic [CW-1:0] idx_q;
  logic          full_q;
  logic          err_q;
  logic          accept;
  logic          beat;

  assign accept = (state_q == IDLE) && miss_valid;
  assign beat   = (state_q == DATA) && rvalid;

  always_comb begin
    state_d      = state_q;
    miss_ready   = 1'b0;
    bus_req      = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    refill_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) state_d = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_grnt) state_d = ADDR;
      end
      ADDR: begin
        bus_req = 1'b1;
        arvalid = 1'b1;
        if (arready) state_d = DATA;
      end
      DATA: begin
        bus_req = 1'b1;
        rready  = 1'b1;
        if (rvalid && rlast) state_d = DONE;
      end
      DONE: begin
        refill_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // full_q marks that every word slot has been written; later beats
  // are overruns and only raise the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      addr_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      addr_q <= miss_addr & ~OMASK;
      idx_q  <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (beat) begin
      if (rresp != 2'b00 || rid != ID) err_q <= 1'b1;
      if (full_q) begin
        err_q <= 1'b1;
      end else begin
        line_q[idx_q] <= rdata;
        idx_q         <= idx_q + 1'b1;
        if (idx_q == LAST) full_q <= 1'b1;
      end
      if (rlast && !full_q && idx_q != LAST) err_q <= 1'b1;
    end
  end

  assign refill_data = line_q;
  assign refill_err  = err_q;
  assign arid        = ID;
  assign araddr      = addr_q;
  assign arlen       = 4'(LINE_WORDS - 1);
  assign arsize      = 3'b010;
  assign arburst     = 2'b01;
  assign arlock      = 2'b00;
  assign arcache     = 4'b0000;
  assign arprot      = 3'b000;

endmodule

// File: tb/tb_axi_line_refill.sv
// Directed bench for axi_line_refill: table of fill scenarios
// plus a reset-in-burst sequence.
module tb_axi_line_refill;

  localparam int         LW  = 8;
  localparam logic [3:0] TID = 4'd0;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                miss_valid;
  logic [31:0]         miss_addr;
  logic                miss_ready;
  logic                refill_valid;
  logic [32*LW-1:0]    refill_data;
  logic                refill_err;
  logic                bus_req;
  logic                bus_grnt;
  logic [3:0]          arid;
  logic [31:0]         araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [3:0]          rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  always #5 clk = ~clk;

  axi_line_refill #(.LINE_WORDS(LW), .ID(TID)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready),
    .refill_valid(refill_valid), .refill_data(refill_data),
    .refill_err(refill_err),
    .bus_req(bus_req), .bus_grnt(bus_grnt),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [31:0] addr;
    int          gd;
    int          ad;
    int          nb;
    logic [31:0] base;
    int          bad_resp;
    int          bad_id;
    logic [31:0] exp_araddr;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [6];
  vec_t        clean;
  vec_t        abortv;
  logic [31:0] exp_line [LW];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm);
    for (int k = 0; k < LW; k++)
      chk(nm, refill_data[32*k +: 32], exp_line[k]);
  endtask

  task automatic do_fill(input vec_t v, input int abort_n);
    @(negedge clk);
    chk("idle_miss_ready", 32'(miss_ready), 32'd1);
    chk("idle_bus_req", 32'(bus_req), 32'd0);
    miss_valid = 1'b1;
    miss_addr  = v.addr;
    @(negedge clk);
    miss_valid = 1'b0;
    chk("req_miss_ready", 32'(miss_ready), 32'd0);
    for (int i = 0; i < v.gd; i++) begin
      chk("req_bus_req", 32'(bus_req), 32'd1);
      chk("req_no_arvalid", 32'(arvalid), 32'd0);
      @(negedge clk);
    end
    bus_grnt = 1'b1;
    @(negedge clk);
    bus_grnt = 1'b0;
    for (int i = 0; i <= v.ad; i++) begin
      chk("arvalid", 32'(arvalid), 32'd1);
      chk("araddr", araddr, v.exp_araddr);
      chk("arlen", 32'(arlen), 32'(LW - 1));
      chk("ar_bus_req", 32'(bus_req), 32'd1);
      if (i == v.ad) arready = 1'b1;
      @(negedge clk);
    end
    arready = 1'b0;
    for (int k = 0; k < v.nb; k++) begin
      if (k == abort_n) return;
      chk("rready", 32'(rready), 32'd1);
      chk("data_bus_req", 32'(bus_req), 32'd1);
      chk("early_refill_valid", 32'(refill_valid), 32'd0);
      rvalid = 1'b1;
      rdata  = v.base + 32'(k);
      rresp  = (k == v.bad_resp) ? 2'b10 : 2'b00;
      rid    = (k == v.bad_id) ? (TID ^ 4'h5) : TID;
      rlast  = (k == v.nb - 1);
      if (k < LW) exp_line[k] = v.base + 32'(k);
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    rid    = TID;
    chk("refill_valid", 32'(refill_valid), 32'd1);
    chk("refill_err", 32'(refill_err), 32'(v.exp_err));
    chk("done_bus_req", 32'(bus_req), 32'd0);
    chk("done_miss_ready", 32'(miss_ready), 32'd0);
    chk_line("refill_word");
    @(negedge clk);
    chk("pulse_end", 32'(refill_valid), 32'd0);
    chk("err_hold", 32'(refill_err), 32'(v.exp_err));
    chk_line("word_hold");
  endtask

  initial begin
    vecs[0] = '{32'h1FC0_0014, 0, 0, 8,  32'h0,   -1, -1,
                32'h1FC0_0000, 1'b0};
    vecs[1] = '{32'h1FC0_0014, 5, 3, 8,  32'h0,   -1, -1,
                32'h1FC0_0000, 1'b0};
    vecs[2] = '{32'h8000_007C, 0, 0, 8,  32'h100,  3, -1,
                32'h8000_0060, 1'b1};
    vecs[3] = '{32'h0000_1234, 0, 0, 6,  32'h200, -1, -1,
                32'h0000_1220, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 1, 2, 10, 32'h300, -1, -1,
                32'hFFFF_FFE0, 1'b1};
    vecs[5] = '{32'h0000_0040, 0, 0, 8,  32'h400, -1,  0,
                32'h0000_0040, 1'b1};
    abortv  = '{32'h2000_0010, 0, 0, 8,  32'h600,  1, -1,
                32'h2000_0000, 1'b1};
    clean   = '{32'h1000_0008, 2, 1, 8,  32'h500, -1, -1,
                32'h1000_0000, 1'b0};
    for (int k = 0; k < LW; k++) exp_line[k] = 32'h0;

    rst_n = 1'b0; miss_valid = 1'b0; miss_addr = '0;
    bus_grnt = 1'b0; arready = 1'b0; rid = TID; rdata = '0;
    rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_refill_valid", 32'(refill_valid), 32'd0);
    chk("rst_refill_err", 32'(refill_err), 32'd0);
    chk_line("rst_word");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_miss_ready", 32'(miss_ready), 32'd1);
    chk("arsize", 32'(arsize), 32'd2);
    chk("arburst", 32'(arburst), 32'd1);

    for (int i = 0; i < 6; i++) do_fill(vecs[i], -1);

    do_fill(abortv, 4);
    chk("pre_rst_rready", 32'(rready), 32'd1);
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    rst_n  = 1'b0;
    #1;
    for (int k = 0; k < LW; k++) exp_line[k] = 32'h0;
    chk("abort_bus_req", 32'(bus_req), 32'd0);
    chk("abort_arvalid", 32'(arvalid), 32'd0);
    chk("abort_rready", 32'(rready), 32'd0);
    chk("abort_refill_valid", 32'(refill_valid), 32'd0);
    chk("abort_refill_err", 32'(refill_err), 32'd0);
    chk_line("abort_word");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_miss_ready", 32'(miss_ready), 32'd1);
    do_fill(clean, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
